// File: rtl/clkdiv_multi.sv
// Multi-channel clock-enable generator: each channel divides clk by a runtime
// divisor and emits a one-cycle tick plus either a square wave or a pulse.
module clkdiv_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 6250000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Config handshake: cfg_we is a single-cycle strobe with no back-pressure;
    // exactly one of cfg_ack / cfg_err pulses on the following cycle.
    logic cfg_ok;
    assign cfg_ok = cfg_we && (cfg_div != '0) && ({1'b0, cfg_ch} < NUM_CH_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_ok;
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic             mode;
        logic             clk_q;
        logic             tick_q;
        logic             pend_v;
        logic [CNT_W-1:0] pend_div;
        logic             pend_mode;
        logic             active;
        logic             terminal;
        logic             mode_chg;
        logic             wr_hit;

        assign active   = en && ch_en[g];
        assign terminal = (cnt == div - ONE);
        assign mode_chg = pend_v && (pend_mode != mode);
        assign wr_hit   = cfg_ok && (cfg_ch == CH_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt       <= '0;
                div       <= DIV_RST;
                mode      <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
                pend_v    <= 1'b0;
                pend_div  <= DIV_RST;
                pend_mode <= 1'b0;
            end else begin
                if (sync) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend_v) begin
                        div    <= pend_div;
                        mode   <= pend_mode;
                        pend_v <= 1'b0;
                    end
                end else if (active && terminal) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    // A mode switch starts the new waveform from low.
                    if (mode_chg)
                        clk_q <= 1'b0;
                    else if (mode)
                        clk_q <= 1'b1;
                    else
                        clk_q <= !clk_q;
                    if (pend_v) begin
                        div    <= pend_div;
                        mode   <= pend_mode;
                        pend_v <= 1'b0;
                    end
                end else if (active) begin
                    cnt    <= cnt + ONE;
                    tick_q <= 1'b0;
                    if (mode)
                        clk_q <= 1'b0;
                end else begin
                    tick_q <= 1'b0;
                    if (mode || mode_chg)
                        clk_q <= 1'b0;
                    // Idle channels pick up new settings without waiting for a wrap.
                    if (pend_v) begin
                        cnt    <= '0;
                        div    <= pend_div;
                        mode   <= pend_mode;
                        pend_v <= 1'b0;
                    end
                end

                // Written after the apply so a same-cycle write stays pending.
                if (wr_hit) begin
                    pend_v    <= 1'b1;
                    pend_div  <= cfg_div;
                    pend_mode <= cfg_mode;
                end
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the divider rules.
module tb_clkdiv_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam int DEF    = 5;
    localparam int CH_W   = 2;
    localparam int W      = 2 * NUM_CH + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic              cfg_mode = 1'b0;
    logic              cfg_ack;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clkdiv_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .sync(sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural state: position within the period, settings, pending write.
    int unsigned m_pos[NUM_CH];
    int unsigned m_div[NUM_CH];
    bit          m_mode[NUM_CH];
    bit          m_clk[NUM_CH];
    bit          m_pv[NUM_CH];
    int unsigned m_pdiv[NUM_CH];
    bit          m_pmode[NUM_CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ok;
        logic [NUM_CH-1:0] e_tick;
        logic [NUM_CH-1:0] e_clk;
        e_tick = '0;
        e_clk  = '0;
        ok = cfg_we && (cfg_div != 0) && (int'(cfg_ch) < NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            bit act;
            bit app;
            bit chg;
            if (rst) begin
                m_pos[c] = 0; m_div[c] = DEF; m_mode[c] = 0; m_clk[c] = 0;
                m_pv[c] = 0; m_pdiv[c] = DEF; m_pmode[c] = 0;
                continue;
            end
            act = en && ch_en[c];
            app = m_pv[c];
            chg = app && (m_pmode[c] != m_mode[c]);
            if (sync) begin
                m_pos[c] = 0;
                m_clk[c] = 0;
            end else if (act && (m_pos[c] + 1 == m_div[c])) begin
                e_tick[c] = 1'b1;
                m_pos[c]  = 0;
                m_clk[c]  = chg ? 1'b0 : (m_mode[c] ? 1'b1 : !m_clk[c]);
            end else if (act) begin
                app = 0;
                m_pos[c]++;
                if (m_mode[c]) m_clk[c] = 0;
            end else begin
                if (app) m_pos[c] = 0;
                if (m_mode[c] || chg) m_clk[c] = 0;
            end
            if (app) begin
                m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c]; m_pv[c] = 0;
            end
            if (ok && int'(cfg_ch) == c) begin
                m_pv[c] = 1; m_pdiv[c] = cfg_div; m_pmode[c] = cfg_mode;
            end
            e_clk[c] = m_clk[c];
        end
        if (rst)
            exp_q.push_back('0);
        else
            exp_q.push_back({cfg_we && !ok, ok, e_clk, e_tick});
    endtask

    task automatic cycle();
        logic [W-1:0] e;
        @(posedge clk);
        model_step();
        #1;
        e = exp_q.pop_front();
        check("tick", tick, e[NUM_CH-1:0]);
        check("clk_out", clk_out, e[2*NUM_CH-1:NUM_CH]);
        check("cfg_ack", cfg_ack, e[2*NUM_CH]);
        check("cfg_err", cfg_err, e[2*NUM_CH+1]);
    endtask

    task automatic write_cfg(input int c, input int d, input bit m);
        cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_div = CNT_W'(d); cfg_mode = m;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic wait_tick(input int c, input int budget, output int n);
        n = 0;
        do begin cycle(); n++; end while (!tick[c] && n < budget);
    endtask

    task automatic wait_level(input int c, input bit v, input int budget, output int n);
        n = 0;
        do begin cycle(); n++; end while (clk_out[c] !== v && n < budget);
    endtask

    initial begin
        int n;
        logic saved;

        // Reset held three cycles.
        repeat (3) cycle();
        check("rst_tick", tick, 0);
        check("rst_clk", clk_out, 0);
        check("rst_ack", cfg_ack, 0);
        rst = 1'b0; en = 1'b1; ch_en = 3'b001;
        wait_tick(0, 50, n);
        check("first_tick_latency", n, DEF);

        // Idle channel takes a new divisor immediately.
        write_cfg(1, 4, 0);
        check("ch1_ack", cfg_ack, 1);
        cycle();
        ch_en = 3'b011;
        wait_tick(1, 50, n);
        check("ch1_first", n, 4);
        wait_tick(1, 50, n);
        check("ch1_period", n, 4);
        wait_level(1, 1'b1, 50, n);
        check("ch1_low", n, 4);
        wait_level(1, 1'b0, 50, n);
        check("ch1_high", n, 4);

        // Running channel finishes its old period before a new divisor.
        write_cfg(2, 6, 0);
        cycle();
        ch_en = 3'b111;
        wait_tick(2, 50, n);
        check("ch2_div6", n, 6);
        repeat (2) cycle();
        write_cfg(2, 3, 0);
        wait_tick(2, 50, n);
        check("ch2_old_tail", n, 3);
        wait_tick(2, 50, n);
        check("ch2_div3", n, 3);
        write_cfg(2, 7, 0);
        write_cfg(2, 3, 0);
        wait_tick(2, 50, n);
        check("ch2_last_wins_a", n, 1);
        wait_tick(2, 50, n);
        check("ch2_last_wins_b", n, 3);

        // Rejected writes.
        write_cfg(2, 0, 0);
        check("div0_err", cfg_err, 1);
        check("div0_ack", cfg_ack, 0);
        write_cfg(3, 5, 0);
        check("badch_err", cfg_err, 1);
        check("badch_ack", cfg_ack, 0);
        wait_tick(2, 50, n);
        wait_tick(2, 50, n);
        check("ch2_unchanged", n, 3);

        // Global enable freeze mid-count.
        wait_tick(1, 50, n);
        repeat (2) cycle();
        en = 1'b0;
        saved = clk_out[1];
        repeat (10) begin
            cycle();
            check("frozen_tick", tick, 0);
        end
        check("frozen_clk", clk_out[1], saved);
        en = 1'b1;
        wait_tick(1, 50, n);
        check("resume", n, 2);

        // Realignment.
        write_cfg(0, 3, 0);
        write_cfg(1, 5, 0);
        repeat (12) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync_tick", tick, 0);
        check("sync_clk", clk_out, 0);
        n = 0;
        do begin cycle(); n++; end while (!(tick[0] && tick[1]) && n < 40);
        check("sync_coincide", n, 15);

        // Divide-by-one pulse mode.
        write_cfg(2, 1, 1);
        repeat (5) cycle();
        repeat (5) begin
            cycle();
            check("div1_tick", tick[2], 1);
            check("div1_clk", clk_out[2], 1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 499) == 0);
            en       = ($urandom_range(0, 9) != 0);
            ch_en    = NUM_CH'($urandom_range(0, 7));
            sync     = ($urandom_range(0, 49) == 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 3));
            cfg_div  = CNT_W'($urandom_range(0, 7));
            cfg_mode = 1'($urandom_range(0, 1));
            cycle();
        end
        rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised multi-channel clock-enable / divided-clock generator.
- Each of NUM_CH channels has its own counter and a runtime-programmable divisor.
- Each channel runs in toggle mode (square wave) or pulse mode (one-cycle tick).
- Feeds slow-clock enables to processor cores, display refresh and debouncers; replaces fixed-constant single dividers.

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 32, counter/divisor width
DEFAULT_DIV, 6250000, divisor loaded into every channel at reset
CH_W, $clog2(NUM_CH) (min 1), width of channel select

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  global count enable
ch_en  in  NUM_CH  per-channel count enable
sync  in  1  realign all channels (counters to 0)
cfg_we  in  1  config write strobe, single cycle
cfg_ch  in  CH_W  channel being configured
cfg_div  in  CNT_W  new divisor D (terminal count = D-1)
cfg_mode  in  1  0 = toggle, 1 = pulse
cfg_ack  out  1  one-cycle pulse: write accepted
cfg_err  out  1  one-cycle pulse: write rejected
clk_out  out  NUM_CH  toggle mode: divided clock; pulse mode: equals tick
tick  out  NUM_CH  one-cycle pulse at each terminal count

Behaviour:
- Reset (rst=1 at clk edge; overrides everything):
  - all counters 0; div = DEFAULT_DIV; mode = toggle; pending flags clear.
  - clk_out = 0, tick = 0, cfg_ack = 0, cfg_err = 0.
- Channel i is active when en && ch_en[i].
- Active channel, count != div-1: count += 1; tick[i] <= 0.
- Active channel, count == div-1 (terminal edge):
  - count <= 0; tick[i] <= 1 for exactly one cycle.
  - Toggle mode: clk_out[i] inverts. Period = 2*div cycles, 50% duty.
  - Pulse mode: clk_out[i] <= 1 for one cycle.
- Inactive channel: count, div and toggle-mode clk_out hold; tick[i] <= 0; pulse-mode clk_out <= 0.
  - No wrap occurs while inactive. Wrap requires enable.
- div = 1 active: tick held high every cycle; toggle-mode clk_out inverts every cycle.
- Config write, registered; responses appear the cycle after cfg_we:
  - Reject when cfg_div == 0 or cfg_ch >= NUM_CH: cfg_err = 1, no state change.
  - Otherwise: pending_div/pending_mode[cfg_ch] <= cfg_div/cfg_mode, pending flag set, cfg_ack = 1.
  - A second write before apply overwrites pending (last write wins).
- Apply pending, then clear the flag:
  - at the channel's next terminal edge, or
  - at the next edge while the channel is inactive, or
  - at sync.
- On apply: count <= 0 and div/mode load. clk_out <= 0 if the mode changes; otherwise clk_out follows the normal terminal rule.
- Write and terminal edge on the same channel in the same cycle: the terminal edge uses the pre-existing pending value, if any. The new write becomes pending and applies at the following terminal edge.
- sync=1 (priority below rst, above counting):
  - all counters 0; all pending configs applied; clk_out = 0; tick = 0.
  - A write in the sync cycle remains pending.
- Latency: tick asserts on the edge where count == div-1 registers. Outputs are fully registered; no combinational path from inputs to outputs.
- No gated clocks. clk_out is a fabric signal; consumers use tick as a clock enable.

Test Plan:
- Reset with rst held 3 cycles -> clk_out = 0, tick = 0, cfg_ack = 0; first tick on ch0 exactly DEFAULT_DIV cycles after rst release with en = 1 (use DEFAULT_DIV = 5 in bench).
- Write ch1 div = 4, toggle, ch1 disabled at the time -> cfg_ack next cycle; after enable, tick every 4 cycles, clk_out period 8, duty 4/4.
- Ch2 running div = 6; write div = 3 at count = 2 -> old period completes (tick at count 5), then ticks every 3 cycles; two writes (7, then 3) -> only 3 applied.
- cfg_div = 0, and cfg_ch = NUM_CH with NUM_CH = 3 -> cfg_err pulse, no ack, behaviour unchanged.
- en = 0 for 10 cycles mid-count at count = 2 -> count and clk_out frozen, no tick; resumes from count 2 and next tick after div-2 more enabled cycles.
- Channels with div 3 and 5 free-running, pulse sync -> both counters 0, clk_out 0; ticks coincide again at 15 cycles after sync. Div = 1 pulse mode -> tick constantly high.
